// File: rtl/routing_matrix_loader_pkg.sv
// Shared definitions for the FM routing matrix loader: parameter defaults,
// host write address field positions and the swap controller state type.
package routing_pkg;

  localparam int DW_DEF        = 16;
  localparam int VOICE_AW_DEF  = 4;
  localparam int N_TARGETS_DEF = 4;
  localparam int N_TERMS_DEF   = 2;

  // wr_addr layout: bit3 selects weight(0)/index(1), bit2 the term,
  // bits1:0 the target.
  localparam int ADDR_SEL_BIT  = 3;
  localparam int ADDR_TERM_BIT = 2;
  localparam int ADDR_TGT_LSB  = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

endpackage

// File: rtl/routing_matrix_loader_bank.sv
// Shadow and active routing banks. Host writes land in the shadow bank only;
// a single copy strobe moves the whole shadow bank into the active bank so
// the consumer never observes a partially updated matrix.
module routing_bank
  import routing_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int VOICE_AW  = VOICE_AW_DEF,
  parameter int N_TARGETS = N_TARGETS_DEF,
  parameter int N_TERMS   = N_TERMS_DEF
) (
  input  logic                                              clk,
  input  logic                                              reset_n,
  input  logic                                              i_wr_en,
  input  logic [3:0]                                        i_wr_addr,
  input  logic [DW-1:0]                                     i_wr_data,
  input  logic                                              i_copy,
  output logic [0:N_TERMS-1][0:N_TARGETS-1][DW-1:0]         o_weights,
  output logic [0:N_TERMS-1][0:N_TARGETS-1][VOICE_AW-1:0]   o_indices
);

  logic                                            w_sel_index;
  logic                                            w_term;
  logic [1:0]                                      w_tgt;
  logic [0:N_TERMS-1][0:N_TARGETS-1][DW-1:0]       r_shadow_w;
  logic [0:N_TERMS-1][0:N_TARGETS-1][VOICE_AW-1:0] r_shadow_i;
  logic [0:N_TERMS-1][0:N_TARGETS-1][DW-1:0]       r_active_w;
  logic [0:N_TERMS-1][0:N_TARGETS-1][VOICE_AW-1:0] r_active_i;

  assign w_sel_index = i_wr_addr[ADDR_SEL_BIT];
  assign w_term      = i_wr_addr[ADDR_TERM_BIT];
  assign w_tgt       = i_wr_addr[ADDR_TGT_LSB +: 2];

  // Store an accepted host write into the addressed shadow entry; index
  // writes keep only the low VOICE_AW bits.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_shadow_w <= '0;
      r_shadow_i <= '0;
    end else if (i_wr_en) begin
      if (w_sel_index) begin
        r_shadow_i[w_term][w_tgt] <= i_wr_data[VOICE_AW-1:0];
      end else begin
        r_shadow_w[w_term][w_tgt] <= i_wr_data;
      end
    end
  end

  // Bulk copy of the complete shadow bank into the active bank.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_active_w <= '0;
      r_active_i <= '0;
    end else if (i_copy) begin
      r_active_w <= r_shadow_w;
      r_active_i <= r_shadow_i;
    end
  end

  assign o_weights = r_active_w;
  assign o_indices = r_active_i;

endmodule

// File: rtl/routing_matrix_loader.sv
// Routing matrix loader top: host write handshake, commit/tick swap
// controller and optional index range check.
// Optional feature macro: ROUTING_IDX_CHECK_EN -- when defined, index writes
// with data bits above VOICE_AW-1 are accepted but dropped and flag wr_err.
module routing_matrix_loader
  import routing_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int VOICE_AW  = VOICE_AW_DEF,
  parameter int N_TARGETS = N_TARGETS_DEF,
  parameter int N_TERMS   = N_TERMS_DEF
) (
  input  logic                                              clk,
  input  logic                                              reset_n,
  input  logic                                              enable,
  input  logic                                              wr_valid,
  output logic                                              wr_ready,
  input  logic [3:0]                                        wr_addr,
  input  logic [DW-1:0]                                     wr_data,
  input  logic                                              commit,
  input  logic                                              sample_tick,
  output logic [0:N_TERMS-1][0:N_TARGETS-1][DW-1:0]         routing_weights,
  output logic [0:N_TERMS-1][0:N_TARGETS-1][VOICE_AW-1:0]   routing_indices,
  output logic                                              pending,
  output logic                                              swap_done,
  output logic                                              wr_err
);

  state_t r_state;
  state_t w_next_state;
  logic   w_copy;
  logic   w_accept;
  logic   w_reject;
  logic   w_store;
  logic   r_swap_done;

  // Swap controller state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Arm on commit while idle; copy the bank and return to idle on an
  // enabled tick while armed. A tick seen in IDLE never copies, even when
  // it coincides with the arming commit.
  always_comb begin
    w_next_state = r_state;
    w_copy       = 1'b0;
    case (r_state)
      IDLE: begin
        if (commit) begin
          w_next_state = ARMED;
        end
      end
      ARMED: begin
        if (sample_tick && enable) begin
          w_next_state = IDLE;
          w_copy       = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign pending  = (r_state == ARMED);
  assign wr_ready = ~pending;
  assign w_accept = wr_valid & wr_ready;
  assign w_store  = w_accept & ~w_reject;

  // Completion pulse in the cycle after the active bank is updated.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_swap_done <= 1'b0;
    end else begin
      r_swap_done <= w_copy;
    end
  end

  assign swap_done = r_swap_done;

`ifdef ROUTING_IDX_CHECK_EN
  logic r_wr_err;

  assign w_reject = wr_addr[ADDR_SEL_BIT] & (|wr_data[DW-1:VOICE_AW]);

  // Flag an accepted-but-dropped out-of-range index write for one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= w_accept & w_reject;
    end
  end

  assign wr_err = r_wr_err;
`else
  assign w_reject = 1'b0;
  assign wr_err   = 1'b0;
`endif

  routing_bank #(
    .DW        (DW),
    .VOICE_AW  (VOICE_AW),
    .N_TARGETS (N_TARGETS),
    .N_TERMS   (N_TERMS)
  ) u_bank (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_wr_en   (w_store),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_copy    (w_copy),
    .o_weights (routing_weights),
    .o_indices (routing_indices)
  );

endmodule

// File: tb/tb_routing_matrix_loader.sv
// Self-checking bench for routing_matrix_loader: a behavioural model of the
// shadow/active banks is compared against the DUT every cycle, and directed
// scenarios pin the model with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_routing_matrix_loader;
  import routing_pkg::*;

  localparam int DW = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b1;
  logic wr_valid = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic commit = 1'b0;
  logic sample_tick = 1'b0;
  logic wr_ready;
  logic pending;
  logic swap_done;
  logic wr_err;
  logic [0:1][0:3][DW-1:0] routing_weights;
  logic [0:1][0:3][AW-1:0] routing_indices;

  int total = 0;
  int bad = 0;
  bit checkOn = 1'b0;

  logic [0:1][0:3][DW-1:0] mShadowW = '0;
  logic [0:1][0:3][DW-1:0] mActiveW = '0;
  logic [0:1][0:3][AW-1:0] mShadowI = '0;
  logic [0:1][0:3][AW-1:0] mActiveI = '0;
  bit mArmed = 1'b0;
  bit mSwapDone = 1'b0;
  bit mErr = 1'b0;

  logic [0:1][0:3][DW-1:0] expW;
  logic [0:1][0:3][AW-1:0] expI;
  int lowCnt;

  always #5 clk = ~clk;

  routing_matrix_loader dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .commit          (commit),
    .sample_tick     (sample_tick),
    .routing_weights (routing_weights),
    .routing_indices (routing_indices),
    .pending         (pending),
    .swap_done       (swap_done),
    .wr_err          (wr_err)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of host inputs away from the edge, then drop the
  // one-shot controls just after the edge that samples them.
  task automatic applyStimulus(input logic v, input logic [3:0] a, input logic [DW-1:0] d,
                               input logic c, input logic t);
    @(negedge clk);
    #2;
    wr_valid = v;
    wr_addr = a;
    wr_data = d;
    commit = c;
    sample_tick = t;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    commit = 1'b0;
    sample_tick = 1'b0;
  endtask

  // Behavioural model: a write is taken whenever the host asks and no swap
  // is armed; an armed swap completes on the first enabled tick.
  always @(posedge clk) begin
    if (!reset_n) begin
      mShadowW = '0;
      mShadowI = '0;
      mActiveW = '0;
      mActiveI = '0;
      mArmed = 1'b0;
      mSwapDone = 1'b0;
      mErr = 1'b0;
    end else begin
      mSwapDone = 1'b0;
      mErr = 1'b0;
      if (wr_valid && !mArmed) begin
        if (wr_addr[3]) begin
`ifdef ROUTING_IDX_CHECK_EN
          if ((wr_data >> AW) != 0) mErr = 1'b1;
          else mShadowI[wr_addr[2]][wr_addr[1:0]] = wr_data[AW-1:0];
`else
          mShadowI[wr_addr[2]][wr_addr[1:0]] = wr_data[AW-1:0];
`endif
        end else begin
          mShadowW[wr_addr[2]][wr_addr[1:0]] = wr_data;
        end
      end
      if (mArmed && sample_tick && enable) begin
        mActiveW = mShadowW;
        mActiveI = mShadowI;
        mArmed = 1'b0;
        mSwapDone = 1'b1;
      end else if (!mArmed && commit) begin
        mArmed = 1'b1;
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("cyc_wr_ready", wr_ready, !mArmed);
      checkOutput("cyc_pending", pending, mArmed);
      checkOutput("cyc_swap_done", swap_done, mSwapDone);
      checkOutput("cyc_wr_err", wr_err, mErr);
      checkOutput("cyc_weights", routing_weights, mActiveW);
      checkOutput("cyc_indices", routing_indices, mActiveI);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset then idle.
    repeat (3) @(posedge clk);
    checkOn = 1'b1;
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rst_wr_ready", wr_ready, 1'b1);
    checkOutput("rst_pending", pending, 1'b0);
    checkOutput("rst_swap_done", swap_done, 1'b0);
    checkOutput("rst_weights", routing_weights, '0);
    checkOutput("rst_indices", routing_indices, '0);

    // Weight 0x1234 to term1/target1, commit, tick.
    applyStimulus(1'b1, 4'h5, 16'h1234, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    expW = '0;
    expW[1][1] = 16'h1234;
    checkOutput("t2_weights", routing_weights, expW);
    checkOutput("t2_w11", routing_weights[1][1], 16'h1234);
    checkOutput("t2_swap_done_hi", swap_done, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("t2_swap_done_lo", swap_done, 1'b0);

    // Index 7 to term0/target2, commit, then a held write stalls until tick.
    applyStimulus(1'b1, 4'hA, 16'h0007, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h0, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    wr_valid = 1'b1;
    wr_addr = 4'h0;
    wr_data = 16'h0055;
    lowCnt = 0;
    for (int k = 0; k < 3; k++) begin
      if (!wr_ready) lowCnt++;
      sample_tick = (k == 2);
      @(posedge clk);
      @(negedge clk);
      #2;
    end
    sample_tick = 1'b0;
    checkOutput("t3_ready_low_cycles", lowCnt, 3);
    checkOutput("t3_idx02", routing_indices[0][2], 4'd7);
    checkOutput("t3_ready_after_tick", wr_ready, 1'b1);
    checkOutput("t3_w00_not_active", routing_weights[0][0], 16'h0000);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    applyStimulus(1'b0, 4'h0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("t3_w00_held_write", routing_weights[0][0], 16'h0055);

    // Write, commit and tick on one edge: arm only, copy at the next tick.
    applyStimulus(1'b1, 4'h3, 16'hBEEF, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("t4_pending", pending, 1'b1);
    checkOutput("t4_no_swap", swap_done, 1'b0);
    checkOutput("t4_w03_old", routing_weights[0][3], 16'h0000);
    applyStimulus(1'b0, 4'h0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("t4_w03_new", routing_weights[0][3], 16'hBEEF);

    // A tick with enable low leaves the swap armed.
    applyStimulus(1'b1, 4'hF, 16'h0009, 1'b1, 1'b0);
    enable = 1'b0;
    applyStimulus(1'b0, 4'h0, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("t5_still_pending", pending, 1'b1);
    checkOutput("t5_idx13_old", routing_indices[1][3], 4'd0);
    enable = 1'b1;
    applyStimulus(1'b0, 4'h0, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("t5_idx13_new", routing_indices[1][3], 4'd9);

    // Reset while armed discards the swap and clears both banks.
    applyStimulus(1'b1, 4'h6, 16'h4242, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(1'b0, 4'h0, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("t6_pending", pending, 1'b0);
    checkOutput("t6_weights", routing_weights, '0);
    checkOutput("t6_indices", routing_indices, '0);
    applyStimulus(1'b0, 4'h0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("t6_shadow_cleared", routing_weights, '0);

    // Out-of-range index write to term0/target0.
    applyStimulus(1'b1, 4'h8, 16'h0013, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    expI = '0;
`ifdef ROUTING_IDX_CHECK_EN
    checkOutput("t7_wr_err", wr_err, 1'b1);
`else
    checkOutput("t7_wr_err", wr_err, 1'b0);
    expI[0][0] = 4'd3;
`endif
    applyStimulus(1'b0, 4'h0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("t7_indices", routing_indices, expI);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/routing_matrix_loader.md
# routing_matrix_loader

Writer side of the FM operator routing matrix. The host control path loads per-target weights and source-voice indices into a shadow bank. The block then swaps the whole bank into the active bank atomically on a sample tick. The active bank drives the routing weight/index inputs of the formatted multiply-add stage, so the arithmetic never sees a half-updated matrix.

## Interface
Parameters:
- DW, 16, weight data width
- VOICE_AW, 4, routing index width (selects one of 2**VOICE_AW routing values)
- N_TARGETS, 4, routing targets per term (fixed to 4 by the consumer)
- N_TERMS, 2, multiply-add terms per target (fixed to 2 by the consumer)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  global enable; gates sample_tick only
- wr_valid  in  1  host write request
- wr_ready  out  1  block can accept a write
- wr_addr  in  4  bit3: 0=weight, 1=index; bit2: term; bits1:0: target
- wr_data  in  DW  write data; index writes use bits VOICE_AW-1:0
- commit  in  1  one-cycle request to arm a shadow-to-active swap
- sample_tick  in  1  one-cycle audio-sample strobe
- routing_weights  out  DW x [0:1][0:3]  active weights
- routing_indices  out  VOICE_AW x [0:1][0:3]  active indices
- pending  out  1  swap armed and waiting for a tick
- swap_done  out  1  one-cycle pulse after an active-bank update
- wr_err  out  1  one-cycle pulse on a rejected write (macro only)

## Operation
- Two FSM states:
  - IDLE: wr_ready=1.
  - ARMED: wr_ready=0, pending=1.
- Write handshake: on every edge with wr_valid&wr_ready, the shadow entry at wr_addr is written. The host holds wr_valid until the write is accepted.
- IDLE→ARMED: on the edge where commit=1. A write accepted on that same edge is stored and included in the swap.
- ARMED→IDLE: on the edge where sample_tick&enable=1. On that edge all 8 weights and 8 indices are copied from shadow to active. swap_done=1 during the next cycle.
- Commit while ARMED: ignored. No error is flagged.
- Tick while IDLE: no effect.
- A commit and a tick on the same edge while in IDLE only arm the swap. The copy happens at a later tick, never in the same cycle.
- The shadow bank is retained after a swap. Partial updates followed by a commit are legal.
- Index writes truncate wr_data to VOICE_AW bits. Upper bits are ignored unless the macro is defined.
- Reset (any cycle, including while ARMED) forces:
  - state to IDLE, which makes wr_ready 1 from the first cycle after reset deasserts;
  - pending=0, swap_done=0, wr_err=0;
  - all shadow and active weights and indices to 0.
  - An armed swap is discarded.

## Timing
- Write latency: the shadow is updated at the accepting edge. It becomes visible on the outputs only via a swap.
- Commit to pending: pending=1 the cycle after the commit edge.
- Tick to outputs: the active outputs change at the tick edge (registered). swap_done follows one cycle later.
- Minimum commit-to-active time is 2 edges: commit at edge N, earliest copy at edge N+1.
- All outputs are registered except wr_ready, which equals ~pending combinationally from state.

## Configuration
- ROUTING_IDX_CHECK_EN defined: an index write with any wr_data bit above VOICE_AW-1 set is accepted (handshake completes) but not stored, and wr_err pulses for one cycle.
- ROUTING_IDX_CHECK_EN undefined: upper bits are silently truncated. wr_err is tied to 0.

## Structure
- Package routing_pkg holds:
  - the DW, VOICE_AW, N_TARGETS and N_TERMS defaults;
  - address field localparams (ADDR_SEL_BIT, ADDR_TERM_BIT, ADDR_TGT_LSB);
  - the FSM state typedef {IDLE, ARMED}.
- Sub-module routing_bank contains the shadow and active register arrays, the write decode, and the bulk copy strobe. The top level holds the FSM, the handshake, and the error check.

## Test plan
- Reset then idle: all outputs 0, wr_ready=1, pending=0.
- Write weight 0x1234 to addr 0x5 (term1, target1), commit, tick: routing_weights[1][1]=0x1234 after the tick edge, swap_done pulses the next cycle, other entries stay 0.
- Write addr 0xA = 7, commit; with wr_valid held, wr_ready=0 for 3 cycles; tick → routing_indices[0][2]=7 and the held write is accepted in the cycle after the tick.
- Commit and tick on the same edge: no swap. The next tick copies the bank.
- Reset asserted while ARMED: pending=0 and the active bank stays 0 after the next tick.
- With ROUTING_IDX_CHECK_EN, writing 0x0013 to index addr 0x8 pulses wr_err and leaves index 0 unchanged. Without the macro, the index becomes 3.
